// File: rtl/pipe_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_pkg
//   Shared pipeline definitions for the generic stage register:
//   - skid_state_t : occupancy state of a stage (EMPTY / BUSY / FULL). The
//                    encoding equals the number of held entries.
//   - NOP_ENCODING : default instruction word driven by an empty stage.
//   - occupancy_of : maps a state to its entry count.
// -----------------------------------------------------------------------------
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam logic [31:0] NOP_ENCODING = 32'h0000_0000;

  // The state encoding is chosen so that it is directly the entry count.
  function automatic logic [1:0] occupancy_of(input skid_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
//   Saturating up-counter for performance monitoring.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset, clears the count
//     inc    : count one event this cycle
//     clr    : synchronous clear, wins over inc
//     count  : current value; sticks at all-ones once reached
// -----------------------------------------------------------------------------
module pipe_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is written with non-blocking (<=) so every flop
  // samples pre-edge values; blocking assignments here make results depend on
  // process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//   Generic pipeline-stage register with a valid/ready handshake and a
//   one-entry skid buffer. in_ready depends on registered state only, so the
//   ready path is cut at every stage boundary while back-to-back throughput
//   stays at one entry per cycle.
//   Ports:
//     clk, rst_n       : clock (rising edge), async active-low reset
//     flush            : synchronous bubble insertion, highest priority
//     clr_stats        : synchronous clear of stall_count
//     in_valid/in_ready: upstream handshake
//     in_data, in_ctrl, in_wr_addr, in_instruction : incoming entry
//     out_valid/out_ready : downstream handshake
//     out_data, out_ctrl, out_wr_addr, out_instruction : main entry; when
//                        empty ctrl/wr_addr read 0 and instruction reads NOP
//     occupancy        : entries held (0, 1 or 2)
//     stall_count      : saturating count of cycles with valid & !ready
// -----------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                           DATA_WIDTH        = 64,
  parameter int                           CTRL_WIDTH        = 8,
  parameter int                           REG_ADDR_WIDTH    = 10,
  parameter int                           INSTRUCTION_WIDTH = 32,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION   = INSTRUCTION_WIDTH'(NOP_ENCODING),
  parameter int                           STALL_CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         clr_stats,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic [REG_ADDR_WIDTH-1:0]    in_wr_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instruction,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic [REG_ADDR_WIDTH-1:0]    out_wr_addr,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [1:0]                   occupancy,
  output logic [STALL_CNT_WIDTH-1:0]   stall_count
);

  skid_state_t state, state_next;

  logic accept;
  logic emit;
  logic load_main_in;    // main <= incoming entry
  logic load_main_skid;  // main <= skid entry
  logic load_skid;       // skid <= incoming entry

  logic [DATA_WIDTH-1:0]        main_data,  skid_data;
  logic [CTRL_WIDTH-1:0]        main_ctrl,  skid_ctrl;
  logic [REG_ADDR_WIDTH-1:0]    main_addr,  skid_addr;
  logic [INSTRUCTION_WIDTH-1:0] main_instr, skid_instr;

  // Handshake: both flags are decoded from the registered state.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign occupancy = occupancy_of(state);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and load strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_next   = BUSY;
        end
      end
      BUSY: begin
        if (accept && emit) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = FULL;
        end else if (emit) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          load_main_skid = 1'b1;
          state_next     = BUSY;
        end
      end
      default: state_next = EMPTY;
    endcase

    // Flush discards everything, including an entry accepted this cycle.
    if (flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // NOTE: datapath registers are often left without reset; these are reset
  // because the post-reset contents of out_* and of the skid entry are visible
  // behaviour of this stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data  <= '0;
      main_ctrl  <= '0;
      main_addr  <= '0;
      main_instr <= NOP_INSTRUCTION;
    end else if (load_main_in) begin
      main_data  <= in_data;
      main_ctrl  <= in_ctrl;
      main_addr  <= in_wr_addr;
      main_instr <= in_instruction;
    end else if (load_main_skid) begin
      main_data  <= skid_data;
      main_ctrl  <= skid_ctrl;
      main_addr  <= skid_addr;
      main_instr <= skid_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data  <= '0;
      skid_ctrl  <= '0;
      skid_addr  <= '0;
      skid_instr <= '0;
    end else if (load_skid) begin
      skid_data  <= in_data;
      skid_ctrl  <= in_ctrl;
      skid_addr  <= in_wr_addr;
      skid_instr <= in_instruction;
    end
  end

  // An empty stage must look like a bubble downstream: no write enables, no
  // destination, NOP instruction. The payload is left as-is (don't-care).
  assign out_data        = main_data;
  assign out_ctrl        = out_valid ? main_ctrl  : '0;
  assign out_wr_addr     = out_valid ? main_addr  : '0;
  assign out_instruction = out_valid ? main_instr : NOP_INSTRUCTION;

  // ---------------------------------------------------------------------------
  // Stall statistics
  // ---------------------------------------------------------------------------
  pipe_sat_counter #(
    .WIDTH (STALL_CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .clr   (clr_stats),
    .count (stall_count)
  );

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Generic, parametrised pipeline-stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data payload, a control-bit vector and the instruction word across a stage boundary using a valid/ready handshake.
- Includes a one-entry skid buffer, so in_ready is a function of registered state only and never depends combinationally on out_ready.
- Adds a synchronous flush that inserts a bubble, plus a saturating stall counter for performance monitoring.

Parameters:
- DATA_WIDTH, 64: payload width; ALU result and HI data are concatenated by the instantiating stage.
- CTRL_WIDTH, 8: control bits (write enables, mux selects); forced to 0 whenever the stage holds no valid entry.
- REG_ADDR_WIDTH, 10: register write-address bits (two 5-bit addresses concatenated).
- INSTRUCTION_WIDTH, 32: instruction word width.
- NOP_INSTRUCTION, 32'h0: value driven on out_instruction when empty or after flush.
- STALL_CNT_WIDTH, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous bubble insertion; highest priority.
- clr_stats  in  1  synchronous clear of stall_count.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  this stage can accept an entry this cycle.
- in_data  in  DATA_WIDTH  payload.
- in_ctrl  in  CTRL_WIDTH  control bits.
- in_wr_addr  in  REG_ADDR_WIDTH  destination register addresses.
- in_instruction  in  INSTRUCTION_WIDTH  instruction word.
- out_valid  out  1  main entry is valid.
- out_ready  in  1  downstream accepts the entry.
- out_data  out  DATA_WIDTH  payload of the main entry.
- out_ctrl  out  CTRL_WIDTH  control bits of the main entry.
- out_wr_addr  out  REG_ADDR_WIDTH  register addresses of the main entry.
- out_instruction  out  INSTRUCTION_WIDTH  instruction of the main entry.
- occupancy  out  2  number of held entries (0, 1 or 2).
- stall_count  out  STALL_CNT_WIDTH  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: a main register (drives the out_* ports) and a skid register (internal).
- Accept condition: in_valid & in_ready. Emit condition: out_valid & out_ready.
- in_ready = (state != FULL), decoded from registered state only.
- State EMPTY (occupancy 0):
  - accept -> load main -> BUSY.
- State BUSY (occupancy 1):
  - accept & emit -> main <= input, stay BUSY. Back-to-back throughput is 1 entry/cycle.
  - accept & !emit -> skid <= input -> FULL.
  - !accept & emit -> EMPTY.
  - !accept & !emit -> hold.
- State FULL (occupancy 2):
  - emit -> main <= skid -> BUSY.
  - otherwise hold. No accept is possible because in_ready=0.
- Latency: an accepted entry appears on out_* on the next cycle when the stage was EMPTY, or when it was BUSY and emitting.
- Ordering is strictly FIFO; no entry is ever duplicated or dropped except by flush.
- Empty-entry contents: whenever main is empty, out_ctrl=0, out_wr_addr=0 and out_instruction=NOP_INSTRUCTION. out_data holds its last value (don't-care).
- Flush (sampled on clk):
  - Next state is EMPTY and both registers are invalidated.
  - An input accepted in the same cycle is discarded.
  - Flush overrides every simultaneous accept and emit.
  - In the flush cycle, in_ready still reflects the pre-flush state.
- stall_count:
  - Increments on each cycle with out_valid & !out_ready and saturates at all-ones.
  - clr_stats has priority over the increment; the counter reads 0 on the following cycle.
  - flush does not clear the counter.
- Reset (rst_n low, asynchronous; takes effect immediately, including mid-transfer):
  - state=EMPTY, so in_ready=1 and out_valid=0.
  - out_data=0, out_ctrl=0, out_wr_addr=0, out_instruction=NOP_INSTRUCTION.
  - skid register=0, occupancy=0, stall_count=0.
- Deassertion of rst_n is assumed synchronised externally.

Decomposition:
- Shared include file (pipeline defines): state encodings EMPTY=2'd0, BUSY=2'd1, FULL=2'd2, and the default NOP encoding.
- One natural sub-module: pipe_sat_counter (parametrised width, with inc, clr and saturation), reused by other performance counters.
- Entry storage stays inline.

Test Plan:
- Reset, then hold in_valid=1 and out_ready=1 and stream data 1..8 -> outputs 1..8 on consecutive cycles starting one cycle after the first accept; in_ready stays 1; occupancy stays 1.
- In BUSY, drop out_ready for 3 cycles while offering A then B -> A held on out_*, B captured in skid, in_ready=0, occupancy=2, stall_count=3. Raise out_ready -> A then B emitted in order, in_ready back to 1.
- In FULL, assert flush together with out_ready=1 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, out_instruction=NOP_INSTRUCTION, occupancy=0; neither the skid entry nor the input reappears.
- Hold out_ready=0 with a valid entry for 2^STALL_CNT_WIDTH+5 cycles -> stall_count saturates at all-ones. Pulse clr_stats while still stalled -> reads 0 next cycle, then increments.
- Assert rst_n low mid-stream while FULL -> outputs take their reset values immediately (asynchronously); after release, the first accept loads cleanly with no stale entry.
- Drive in_valid=1 with out_ready random (seeded) for 1000 cycles -> a scoreboard confirms in-order, lossless delivery and in_ready == (occupancy != 2) on every cycle.
